// File: rtl/cas_tape_player_if.sv
// Byte stream handshake into the cassette player FIFO.
// A byte is transferred on a clock where in_valid and in_ready are both high.
interface cas_tape_player_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (output in_data, output in_valid, input  in_ready);
    modport slave  (input  in_data, input  in_valid, output in_ready);
endinterface

// File: rtl/cas_tape_player.sv
// Colour Genie cassette pulse-train player: buffers CAS bytes and plays them MSB-first as clock/data pulses.
// Optional macro CAS_MOTOR_EN adds a motor input that freezes the serialiser while low.
module cas_tape_player #(
    parameter int unsigned BIT_CYCLES   = 29556,
    parameter int unsigned PULSE_CYCLES = 1478,
    parameter int unsigned FIFO_AW      = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    cas_tape_player_if.slave     in_bus,
    input  logic                 play,
    input  logic                 flush,
`ifdef CAS_MOTOR_EN
    input  logic                 motor,
`endif
    output logic                 tape_out,
    output logic                 busy,
    output logic                 underrun,
    output logic [23:0]          byte_count
);
    localparam int unsigned DEPTH = 2 ** FIFO_AW;
    localparam int unsigned CW    = $clog2(BIT_CYCLES);

    localparam logic [FIFO_AW:0] C_DEPTH     = (FIFO_AW + 1)'(DEPTH);
    localparam logic [CW-1:0]    C_PULSE_END = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0]    C_HALF_END  = CW'(BIT_CYCLES / 2 - 1);
    localparam logic [CW-1:0]    C_DATA_END  = CW'(BIT_CYCLES / 2 + PULSE_CYCLES - 1);
    localparam logic [CW-1:0]    C_CELL_END  = CW'(BIT_CYCLES - 1);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_LOAD       = 3'd1;
    localparam logic [2:0] S_CLK_PULSE  = 3'd2;
    localparam logic [2:0] S_CLK_GAP    = 3'd3;
    localparam logic [2:0] S_DATA_PULSE = 3'd4;
    localparam logic [2:0] S_DATA_GAP   = 3'd5;

    logic [7:0]         r_mem [DEPTH];
    logic [7:0]         r_rd_data;
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_count;

    logic [2:0]         r_state;
    logic [CW-1:0]      r_cnt;
    logic [7:0]         r_shift;
    logic [2:0]         r_bit_idx;
    logic               r_tape;
    logic               r_underrun;
    logic               r_uflag;
    logic [23:0]        r_byte_count;

    logic               w_run;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic [2:0]         w_state_next;
    logic [CW-1:0]      w_cnt_next;
    logic [7:0]         w_shift_next;
    logic [2:0]         w_bit_next;
    logic               w_byte_done;
    logic               w_underrun_next;
    logic               w_uflag_next;
    logic               w_tape_next;

`ifdef CAS_MOTOR_EN
    assign w_run = motor;
`else
    assign w_run = 1'b1;
`endif

    // in_ready comes from the registered count, so a pop never opens a slot in the same cycle
    assign w_full          = (r_count == C_DEPTH);
    assign w_empty         = (r_count == '0);
    assign in_bus.in_ready = ~w_full;
    assign w_push          = in_bus.in_valid & ~w_full & ~flush;
    assign w_pop           = (r_state == S_LOAD) & w_run;

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_bus.in_data;
        end
        r_rd_data <= r_mem[r_rd_ptr];
    end

    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_shift_next    = r_shift;
        w_bit_next      = r_bit_idx;
        w_byte_done     = 1'b0;
        w_underrun_next = 1'b0;
        w_uflag_next    = w_empty ? r_uflag : 1'b0;
        if (w_run) begin
            case (r_state)
                S_IDLE: begin
                    if (play) begin
                        if (!w_empty) begin
                            w_state_next = S_LOAD;
                        end else if (!r_uflag) begin
                            w_underrun_next = 1'b1;
                            w_uflag_next    = 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    w_shift_next = r_rd_data;
                    w_bit_next   = 3'd7;
                    w_cnt_next   = '0;
                    w_state_next = S_CLK_PULSE;
                end
                S_CLK_PULSE: begin
                    w_cnt_next = r_cnt + CW'(1);
                    if (r_cnt == C_PULSE_END) w_state_next = S_CLK_GAP;
                end
                S_CLK_GAP: begin
                    w_cnt_next = r_cnt + CW'(1);
                    if (r_cnt == C_HALF_END) w_state_next = S_DATA_PULSE;
                end
                S_DATA_PULSE: begin
                    w_cnt_next = r_cnt + CW'(1);
                    if (r_cnt == C_DATA_END) w_state_next = S_DATA_GAP;
                end
                S_DATA_GAP: begin
                    if (r_cnt == C_CELL_END) begin
                        w_cnt_next   = '0;
                        w_shift_next = {r_shift[6:0], 1'b0};
                        w_bit_next   = r_bit_idx - 3'd1;
                        if (r_bit_idx == 3'd0) begin
                            // play is only honoured here, so bytes are never cut short
                            w_byte_done = 1'b1;
                            if (play && !w_empty) begin
                                w_state_next = S_LOAD;
                            end else begin
                                w_state_next = S_IDLE;
                                if (play) begin
                                    w_underrun_next = 1'b1;
                                    w_uflag_next    = 1'b1;
                                end
                            end
                        end else begin
                            w_state_next = S_CLK_PULSE;
                        end
                    end else begin
                        w_cnt_next = r_cnt + CW'(1);
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end
        // Output level derived from the state being entered keeps tape_out aligned and registered
        w_tape_next = (w_state_next == S_CLK_PULSE) ||
                      ((w_state_next == S_DATA_PULSE) && w_shift_next[7]);
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_shift      <= '0;
            r_bit_idx    <= '0;
            r_tape       <= 1'b0;
            r_underrun   <= 1'b0;
            r_uflag      <= 1'b0;
            r_byte_count <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (FIFO_AW + 1)'(1);
                2'b01:   r_count <= r_count - (FIFO_AW + 1)'(1);
                default: r_count <= r_count;
            endcase
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_shift    <= w_shift_next;
            r_bit_idx  <= w_bit_next;
            r_tape     <= w_tape_next;
            r_underrun <= w_underrun_next;
            r_uflag    <= w_uflag_next;
            if (w_byte_done && (r_byte_count != 24'hFFFFFF)) begin
                r_byte_count <= r_byte_count + 24'd1;
            end
        end
    end

    assign tape_out   = r_tape;
    assign busy       = (r_state != S_IDLE);
    assign underrun   = r_underrun;
    assign byte_count = r_byte_count;
endmodule

// File: tb/tb_cas_tape_player.sv
// Bench for cas_tape_player: vector table, hand-written corner sequences and a randomized
// run whose tape output is decoded back into bytes and compared against the pushed stream.
module tb_cas_tape_player;
    localparam int BC = 40;
    localparam int PC = 4;
    localparam int AW = 2;

    logic        clock;
    logic        reset;
    logic        play;
    logic        flush;
    logic        tape_out;
    logic        busy;
    logic        underrun;
    logic [23:0] byte_count;
`ifdef CAS_MOTOR_EN
    logic        motor;
`endif

    cas_tape_player_if bus();

    cas_tape_player #(.BIT_CYCLES(BC), .PULSE_CYCLES(PC), .FIFO_AW(AW)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_bus     (bus),
        .play       (play),
        .flush      (flush),
`ifdef CAS_MOTOR_EN
        .motor      (motor),
`endif
        .tape_out   (tape_out),
        .busy       (busy),
        .underrun   (underrun),
        .byte_count (byte_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic [7:0] data;
        int         rises;
        int         highs;
        int         busy_cyc;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // tape decoder state: rebuilds bytes purely from pulse positions on tape_out
    bit         mon_en = 1'b0;
    int         n_cyc  = 0;
    int         m_rise = 0;
    int         m_hi   = 0;
    bit         m_prev = 1'b0;
    bit         m_in_cell = 1'b0;
    bit         m_dbit = 1'b0;
    int         m_nbits = 0;
    logic [7:0] m_sh = '0;
    logic [7:0] exp_q[$];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        logic [7:0] e;
        @(negedge clock);
        n_cyc++;
        if (!mon_en) begin
            m_in_cell = 1'b0;
            m_nbits   = 0;
            m_hi      = 0;
            m_prev    = tape_out;
            return;
        end
        if (tape_out) m_hi++;
        if (!tape_out && m_prev) begin
            chk("pulse_width", m_hi, PC);
            m_hi = 0;
        end
        if (tape_out && !m_prev) begin
            if (m_in_cell && (n_cyc - m_rise == BC / 2)) begin
                m_dbit = 1'b1;
            end else if (!m_in_cell) begin
                if (m_nbits != 0) chk("cell_len", n_cyc - m_rise, BC);
                m_rise    = n_cyc;
                m_in_cell = 1'b1;
                m_dbit    = 1'b0;
            end else begin
                chk("stray_pulse_offset", n_cyc - m_rise, BC / 2);
            end
        end
        if (m_in_cell && (n_cyc - m_rise == BC - 1)) begin
            m_sh      = {m_sh[6:0], m_dbit};
            m_nbits++;
            m_in_cell = 1'b0;
            if (m_nbits == 8) begin
                m_nbits = 0;
                if (exp_q.size() == 0) begin
                    chk("extra_byte", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    $display("decoded byte %h, expected %h", m_sh, e);
                    chk("byte_order", m_sh, e);
                end
            end
        end
        m_prev = tape_out;
    endtask

    task automatic push_byte(input logic [7:0] b);
        bit ok = 1'b0;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 2000 && !ok; i++) begin
            if (bus.in_ready) begin
                ok = 1'b1;
                if (mon_en) exp_q.push_back(b);
                $display("push byte %h", b);
            end
            tick();
        end
        bus.in_valid = 1'b0;
        if (!ok) chk("push_timeout", ok, 1);
    endtask

    task automatic drain(input string name);
        int i;
        for (i = 0; i < 20000; i++) begin
            if (exp_q.size() == 0 && !busy && m_nbits == 0 && !m_in_cell) break;
            tick();
        end
        chk(name, exp_q.size(), 0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int rises = 0, highs = 0, bcyc = 0, urs = 0, idle = 0;
        bit seen = 1'b0, prev = 1'b0;
        logic [23:0] bc0;
        bc0 = byte_count;
        push_byte(v.data);
        play = 1'b1;
        for (int i = 0; i < 800 && idle < 5; i++) begin
            tick();
            if (busy) begin
                bcyc++;
                seen = 1'b1;
            end else if (seen) begin
                idle++;
            end
            if (tape_out) highs++;
            if (tape_out && !prev) rises++;
            prev = tape_out;
            if (underrun) urs++;
        end
        play = 1'b0;
        tick();
        chk("vec_finished", idle, 5);
        chk("vec_busy_cycles", bcyc, v.busy_cyc);
        chk("vec_pulse_count", rises, v.rises);
        chk("vec_high_cycles", highs, v.highs);
        chk("vec_underrun", urs, 1);
        chk("vec_byte_count", byte_count, bc0 + 24'd1);
        $display("vector %0d byte %h: pulses %0d high %0d busy %0d", idx, v.data, rises, highs, bcyc);
    endtask

    initial begin
        vec_t vecs[5];
        int   w, bsy, urs, nr;
        logic [23:0] bc0;

        vecs[0] = '{8'hA5, 12, 48, 321};
        vecs[1] = '{8'h00,  8, 32, 321};
        vecs[2] = '{8'hFF, 16, 64, 321};
        vecs[3] = '{8'h80,  9, 36, 321};
        vecs[4] = '{8'h01,  9, 36, 321};

        reset = 1'b1; play = 1'b0; flush = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0;
`ifdef CAS_MOTOR_EN
        motor = 1'b1;
`endif
        repeat (3) tick();
        chk("reset_in_ready", bus.in_ready, 1);
        chk("reset_tape_out", tape_out, 0);
        chk("reset_busy", busy, 0);
        chk("reset_underrun", underrun, 0);
        chk("reset_byte_count", byte_count, 0);
        reset = 1'b0;
        tick();

        // empty FIFO with play high: a single underrun pulse, nothing on tape
        play = 1'b1;
        urs = 0; bsy = 0; w = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (underrun) urs++;
            if (busy) bsy++;
            if (tape_out) w++;
        end
        play = 1'b0;
        tick();
        chk("empty_underrun_pulses", urs, 1);
        chk("empty_busy_cycles", bsy, 0);
        chk("empty_tape_high", w, 0);
        $display("empty play: underrun pulses %0d", urs);

        for (int k = 0; k < 5; k++) run_vec(vecs[k], k);

        // fill the 4-deep FIFO, fifth byte must wait for the first pop
        mon_en = 1'b1;
        tick();
        bc0 = byte_count;
        for (int k = 0; k < 4; k++) push_byte(8'h10 + 8'(k));
        chk("full_in_ready", bus.in_ready, 0);
        bus.in_data = 8'h5E; bus.in_valid = 1'b1; play = 1'b1;
        w = 0;
        while (!bus.in_ready && w < 100) begin
            tick();
            w++;
        end
        chk("full_hold_cycles", w, 2);
        chk("busy_at_first_pop", busy, 1);
        exp_q.push_back(8'h5E);
        $display("push byte 5e after %0d wait cycles", w);
        tick();
        bus.in_valid = 1'b0;
        drain("fifo5_drained");
        chk("fifo5_byte_count", byte_count, bc0 + 24'd5);
        play = 1'b0;
        tick();

        // drop play mid byte: byte completes, second byte stays queued
        bc0 = byte_count;
        push_byte(8'hFF);
        push_byte(8'h3C);
        play = 1'b1;
        repeat (170) tick();
        play = 1'b0;
        for (int i = 0; i < 400 && busy; i++) tick();
        chk("drop_idle", busy, 0);
        chk("drop_byte_count", byte_count, bc0 + 24'd1);
        chk("drop_queued_left", exp_q.size(), 1);
        bsy = 0; urs = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (busy) bsy++;
            if (underrun) urs++;
        end
        chk("drop_stays_idle", bsy, 0);
        chk("drop_no_underrun", urs, 0);
        chk("drop_count_hold", byte_count, bc0 + 24'd1);
        play = 1'b1;
        drain("drop_resume_drained");
        chk("drop_resume_count", byte_count, bc0 + 24'd2);
        play = 1'b0;
        tick();

        // flush mid byte with two bytes queued and a colliding push
        mon_en = 1'b0;
        push_byte(8'hAA);
        push_byte(8'h55);
        push_byte(8'hC3);
        play = 1'b1;
        repeat (90) tick();
        flush = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'h77;
        tick();
        flush = 1'b0; bus.in_valid = 1'b0;
        chk("flush_tape_out", tape_out, 0);
        chk("flush_busy", busy, 0);
        chk("flush_in_ready", bus.in_ready, 1);
        chk("flush_byte_count", byte_count, 0);
        bsy = 0; urs = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (busy) bsy++;
            if (underrun) urs++;
        end
        chk("flush_fifo_empty", bsy, 0);
        chk("flush_underrun", urs, 1);
        $display("flush: busy cycles after %0d, underruns %0d", bsy, urs);
        play = 1'b0;
        tick();

        // random byte stream with random gaps, checked by the tape decoder
        mon_en = 1'b1;
        tick();
        play = 1'b1;
        nr = 24;
        for (int k = 0; k < nr; k++) begin
            w = ($urandom_range(0, 3) == 0) ? int'($urandom_range(300, 500)) : int'($urandom_range(0, 20));
            repeat (w) tick();
            push_byte(8'($urandom));
        end
        drain("random_drained");
        chk("random_byte_count", byte_count, nr);
        play = 1'b0;
        tick();

`ifdef CAS_MOTOR_EN
        begin
            int hi = 0, frz = 0;
            bit did = 1'b0;
            mon_en = 1'b0;
            bc0 = byte_count;
            push_byte(8'h00);
            play = 1'b1;
            for (int i = 0; i < 400; i++) begin
                tick();
                if (tape_out) hi++;
                else if (hi != 0) break;
                if (did && !motor) begin
                    frz++;
                    if (frz == 100) motor = 1'b1;
                end
                if (hi == 2 && !did) begin
                    motor = 1'b0;
                    did = 1'b1;
                end
            end
            chk("motor_stretched_pulse", hi, 104);
            for (int i = 0; i < 800 && busy; i++) tick();
            chk("motor_byte_done", byte_count, bc0 + 24'd1);
            $display("motor: stretched pulse %0d cycles", hi);
            play = 1'b0;
            tick();
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
